shift_issue: RTL
================

SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  command offered.
REQ-005 SHALL have port in_ready  output  1  queue can accept command.
REQ-006 SHALL have port in_data  input  8  operand to shift.
REQ-007 SHALL have port in_sel  input  3  shift amount, 0..7.
REQ-008 SHALL have port in_dir  input  1  1 = left shift, 0 = right shift.
REQ-009 SHALL have port sh_x  output  8  operand to downstream combinational shifter.
REQ-010 SHALL have port sh_sel  output  3  shift amount to shifter.
REQ-011 SHALL have port sh_dir  output  1  direction to shifter.
REQ-012 SHALL have port sh_y  input  8  shifter result, combinational from sh_x/sh_sel/sh_dir.
REQ-013 SHALL have port out_valid  output  1  result register holds valid result.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port out_data  output  8  registered result.
REQ-016 SHALL have port level  output  5  current queue occupancy.

Function
REQ-017 SHALL store each command {in_data, in_sel, in_dir} in a FIFO on the edge where in_valid and in_ready are both 1.
REQ-018 SHALL drive in_ready = 1 iff level < DEPTH and rst_n = 1; a push offered while full is ignored, with no state change.
REQ-019 SHALL drive sh_x/sh_sel/sh_dir from the FIFO head entry when level > 0; drive all zero when empty.
REQ-020 SHALL pop the head and capture sh_y into out_data on an edge where level > 0 and the result slot is free (out_valid = 0, or out_ready = 1 on that edge).
REQ-021 SHALL set out_valid on a capture edge; clear it on an edge with out_valid & out_ready and no capture.
REQ-022 SHALL hold out_data and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL handle simultaneous push and pop in one edge with level unchanged; push uses the pre-edge in_ready value.
REQ-024 SHALL deliver results in command order, one per cycle sustained when out_ready stays high.
REQ-025 SHALL have latency 2 edges from acceptance to out_valid when the queue and result slot are empty; no same-cycle bypass.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; level = write count minus read count, 0..DEPTH.
REQ-027 SHALL pass in_sel = 0 through the shifter unchanged; there is no special case.

Reset
REQ-028 SHALL, on an edge with rst_n = 0, clear pointers, level, out_valid, and out_data to 0, discarding queued and pending results.
REQ-029 SHALL hold in_ready = 0 and sh_* = 0 while rst_n = 0; a mid-operation reset loses all in-flight commands with no partial output.

Configuration
REQ-030 SHALL, with macro SHIFT_ISSUE_LOSS_EN defined, add output out_loss (1 bit): registered alongside out_data, 1 iff a 1-bit was shifted out.
- Left: any of head bits [7:8-sel] set.
- Right: any of bits [sel-1:0] set.
- sel = 0 gives 0.
REQ-031 SHALL, without SHIFT_ISSUE_LOSS_EN, omit the out_loss port and its logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover: reset, then push {0x81, sel 1, left} -> out_valid at 2nd edge after accept, out_data 0x02, out_loss 1 (if enabled).
REQ-033 SHALL cover: push {0xF0, sel 3, right} -> out_data 0x1E, out_loss 0; push {0x5A, sel 0, left} -> 0x5A.
REQ-034 SHALL cover: out_ready = 0, push 5 commands with DEPTH 4 -> 4 in queue plus 1 in result slot; in_ready = 0; level = 4; release out_ready -> 5 results in order, 1 per cycle.
REQ-035 SHALL cover: full queue with simultaneous in_valid and out_ready -> no push that edge; level drops to 3; in_ready rises next cycle.
REQ-036 SHALL cover: rst_n low for 1 edge with 3 queued and out_valid = 1 -> level 0, out_valid 0, next out_data only from new commands.
REQ-037 SHALL cover: 20 random commands through pointer wrap -> outputs match reference shift model with zero fill.

Source files
------------

// File: rtl/shift_issue.sv
// Command queue feeding an external combinational shifter, with a one-entry result slot.
// Optional: define SHIFT_ISSUE_LOSS_EN to add out_loss (a set bit was shifted out).
module shift_issue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] in_sel,
    input  logic       in_dir,
    output logic [7:0] sh_x,
    output logic [2:0] sh_sel,
    output logic       sh_dir,
    input  logic [7:0] sh_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [4:0] level
`ifdef SHIFT_ISSUE_LOSS_EN
    ,
    output logic       out_loss
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 12;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [4:0]    level_reg;
    logic          out_valid_reg;
    logic [7:0]    out_data_reg;
    logic [EW-1:0] head;
    logic          not_empty;
    logic          head_live;
    logic          push;
    logic          pop;

    assign not_empty = (level_reg != 5'd0);
    assign head_live = rst_n && not_empty;
    assign in_ready  = rst_n && (level_reg < 5'(DEPTH));
    assign push      = in_valid && in_ready;
    // The result slot is free if empty or being drained on this same edge.
    assign pop       = head_live && (!out_valid_reg || out_ready);
    assign head      = mem[rd_ptr_reg];

    always_comb begin
        sh_x   = 8'd0;
        sh_sel = 3'd0;
        sh_dir = 1'b0;
        if (head_live) begin
            sh_x   = head[11:4];
            sh_sel = head[3:1];
            sh_dir = head[0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_data, in_sel, in_dir};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= 5'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 5'd1;
                2'b01:   level_reg <= level_reg - 5'd1;
                default: level_reg <= level_reg;
            endcase
            if (pop) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= sh_y;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign level     = level_reg;

`ifdef SHIFT_ISSUE_LOSS_EN
    logic [7:0] left_mask;
    logic [7:0] right_mask;
    logic       loss_next;
    logic       out_loss_reg;

    // Left shift by sel drops bits [7:8-sel]; right shift drops bits [sel-1:0].
    for (genvar gi = 0; gi < 8; gi++) begin : g_loss_mask
        assign left_mask[gi]  = ({1'b0, sh_sel} + 4'(gi)) >= 4'd8;
        assign right_mask[gi] = 3'(gi) < sh_sel;
    end

    assign loss_next = |(sh_x & (sh_dir ? left_mask : right_mask));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_loss_reg <= 1'b0;
        end else if (pop) begin
            out_loss_reg <= loss_next;
        end
    end

    assign out_loss = out_loss_reg;
`endif

endmodule
